mixed_weight_packer: RTL

- Encoder side of the PE mixed-precision weight path.
- Takes a vector of eight 8-bit unsigned weights and emits one or more 4-bit lane beats plus sel/addr side-band, in the exact format the PE weight unpacker consumes.
- A weight ≥16 is an outlier. Its high nibble rides in a zero-valued donor lane of the same beat; addr = {outlier_lane, donor_lane}.
- Multiple outliers, or a missing donor, are split across beats. Sits between the weight buffer reader and the PE array weight inputs.

---
 rtl/mixed_weight_packer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mixed_weight_packer.sv
// Splits a vector of eight 8-bit weights into 4-bit lane beats, routing each
// outlier's high nibble through a zero-valued donor lane (addr = {outlier, donor}).
module mixed_weight_packer #(
   parameter int LANES = 8,
   parameter int IW    = 8,
   parameter int OW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] w_in0,
   input  logic [IW-1:0] w_in1,
   input  logic [IW-1:0] w_in2,
   input  logic [IW-1:0] w_in3,
   input  logic [IW-1:0] w_in4,
   input  logic [IW-1:0] w_in5,
   input  logic [IW-1:0] w_in6,
   input  logic [IW-1:0] w_in7,
   input  logic          mod,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] weight_0,
   output logic [OW-1:0] weight_1,
   output logic [OW-1:0] weight_2,
   output logic [OW-1:0] weight_3,
   output logic [OW-1:0] weight_4,
   output logic [OW-1:0] weight_5,
   output logic [OW-1:0] weight_6,
   output logic [OW-1:0] weight_7,
   output logic          sel,
   output logic [5:0]    addr,
   output logic          out_last
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   in_vec     [LANES];
   logic [IW-1:0]   vec_reg    [LANES];
   logic [OW-1:0]   weight_reg [LANES];
   logic [LANES-1:0] in_mask;
   logic [LANES-1:0] rem_reg;
   logic            sel_reg;
   logic [5:0]      addr_reg;
   logic            last_reg;

   logic [IW-1:0]   src_vec    [LANES];
   logic [LANES-1:0] src_mask;
   logic [OW-1:0]   beat_w     [LANES];
   logic [LANES-1:0] mask_next;
   logic            sel_next;
   logic [5:0]      addr_next;
   logic            last_next;
   logic [2:0]      p, d;
   logic            d_found;

   logic            hs, cap, load;

   assign in_vec[0] = w_in0;
   assign in_vec[1] = w_in1;
   assign in_vec[2] = w_in2;
   assign in_vec[3] = w_in3;
   assign in_vec[4] = w_in4;
   assign in_vec[5] = w_in5;
   assign in_vec[6] = w_in6;
   assign in_vec[7] = w_in7;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_mask
         assign in_mask[gi] = (in_vec[gi][IW-1:OW] != '0) && !mod;
      end
   endgenerate

   assign out_valid = (state_reg == EMIT);
   assign hs        = out_valid && out_ready;
   assign in_ready  = (state_reg == IDLE) || (hs && last_reg);
   assign cap       = in_valid && in_ready;
   assign load      = cap || (hs && !last_reg);

   // A newly captured vector produces its first beat; otherwise the stored
   // vector and remaining mask produce the next follow-up beat.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         src_vec[k] = cap ? in_vec[k] : vec_reg[k];
      end
      src_mask = cap ? in_mask : rem_reg;
   end

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         beat_w[k] = '0;
      end
      mask_next = src_mask;
      sel_next  = 1'b0;
      addr_next = '0;
      p         = '0;
      d         = '0;
      d_found   = 1'b0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (src_mask[k]) p = k[2:0];
      end
      if (cap) begin
         for (int k = 0; k < LANES; k++) begin
            beat_w[k] = (src_mask[k] && (k[2:0] != p)) ? '0 : src_vec[k][OW-1:0];
         end
         for (int k = LANES - 1; k >= 0; k--) begin
            if ((k[2:0] != p) && (beat_w[k] == '0)) begin
               d       = k[2:0];
               d_found = 1'b1;
            end
         end
         if (src_mask != '0) begin
            if (d_found) begin
               beat_w[d]    = src_vec[p][IW-1:OW];
               sel_next     = 1'b1;
               addr_next    = {p, d};
               mask_next[p] = 1'b0;
            end else begin
               // No zero lane to borrow: the outlier is deferred to a later beat.
               beat_w[p] = '0;
            end
         end
      end else begin
         d            = (p != 3'd0) ? 3'd0 : 3'd1;
         beat_w[p]    = src_vec[p][OW-1:0];
         beat_w[d]    = src_vec[p][IW-1:OW];
         sel_next     = 1'b1;
         addr_next    = {p, d};
         mask_next[p] = 1'b0;
      end
      last_next = (mask_next == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cap) state_next = EMIT;
         EMIT:    if (hs && last_reg) state_next = cap ? EMIT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) begin
            vec_reg[k]    <= '0;
            weight_reg[k] <= '0;
         end
         rem_reg  <= '0;
         sel_reg  <= 1'b0;
         addr_reg <= '0;
         last_reg <= 1'b0;
      end else if (load) begin
         for (int k = 0; k < LANES; k++) begin
            if (cap) vec_reg[k] <= in_vec[k];
            weight_reg[k] <= beat_w[k];
         end
         rem_reg  <= mask_next;
         sel_reg  <= sel_next;
         addr_reg <= addr_next;
         last_reg <= last_next;
      end else if (hs && last_reg) begin
         for (int k = 0; k < LANES; k++) begin
            weight_reg[k] <= '0;
         end
         rem_reg  <= '0;
         sel_reg  <= 1'b0;
         addr_reg <= '0;
         last_reg <= 1'b0;
      end
   end

   assign weight_0 = weight_reg[0];
   assign weight_1 = weight_reg[1];
   assign weight_2 = weight_reg[2];
   assign weight_3 = weight_reg[3];
   assign weight_4 = weight_reg[4];
   assign weight_5 = weight_reg[5];
   assign weight_6 = weight_reg[6];
   assign weight_7 = weight_reg[7];
   assign sel      = sel_reg;
   assign addr     = addr_reg;
   assign out_last = last_reg;

endmodule
